// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: one valid/ready request becomes one
// bus cycle, answered with read data or a timeout error on the response channel.
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_sel,
  input  logic              req_we,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i
);

  localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= 4'h0;
      adr_q        <= '0;
      dat_q        <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    sel_d        = sel_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          adr_d       = req_addr;
          dat_d       = req_wdata;
          sel_d       = req_sel;
          we_d        = req_we;
          cyc_d       = 1'b1;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          state_d     = S_BUS;
        end else begin
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_BUS: begin
        // ACK wins over the timeout, so an ACK in the last allowed cycle succeeds.
        if (wbm_ack_i) begin
          resp_rdata_d = we_q ? 32'h0 : wbm_dat_i;
          resp_err_d   = 1'b0;
          cyc_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_rdata_d = 32'h0;
          resp_err_d   = 1'b1;
          cyc_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        cyc_d        = 1'b0;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = cyc_q;
  assign wbm_we_o   = we_q;
  assign wbm_sel_o  = sel_q;
  assign wbm_adr_o  = adr_q;
  assign wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator with TIMEOUT=8.
module tb_wb_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_sel;
  logic        req_we;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        cyc, stb, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic        ack;

  int tests  = 0;
  int failed = 0;
  int stb_cycles;
  logic stable;

  wb_initiator #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_sel   (req_sel),
    .req_we    (req_we),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we_o),
    .wbm_sel_o (sel_o),
    .wbm_adr_o (adr_o),
    .wbm_dat_o (dat_o),
    .wbm_dat_i (dat_i),
    .wbm_ack_i (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
    req_valid = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_sel   = s;
    req_we    = w;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_sel = 4'h0; req_we = 1'b0;
    resp_ready = 1'b0; dat_i = 32'h0; ack = 1'b0;

    // Reset state
    #3;
    chk("rst_cyc", {63'd0, cyc}, 64'd0);
    chk("rst_stb", {63'd0, stb}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_adr", {32'd0, adr_o}, 64'd0);
    #9 rst = 1'b0;
    tick();
    chk("rel_req_ready", {63'd0, req_ready}, 64'd1);

    // Write, ACK in second STB cycle
    request(32'h3000_0000, 32'h0000_000D, 4'hF, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("wr_stb", {63'd0, stb}, 64'd1);
    chk("wr_cyc", {63'd0, cyc}, 64'd1);
    chk("wr_adr", {32'd0, adr_o}, 64'h3000_0000);
    chk("wr_we", {63'd0, we_o}, 64'd1);
    chk("wr_dat", {32'd0, dat_o}, 64'h0000_000D);
    chk("wr_sel", {60'd0, sel_o}, 64'hF);
    chk("wr_req_ready", {63'd0, req_ready}, 64'd0);
    tick();
    chk("wr_stb_2nd", {63'd0, stb}, 64'd1);
    ack = 1'b1; dat_i = 32'h9999_9999;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    chk("wr_stb_drop", {63'd0, stb}, 64'd0);
    chk("wr_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("wr_resp_err", {63'd0, resp_err}, 64'd0);
    chk("wr_resp_rdata", {32'd0, resp_rdata}, 64'd0);
    resp_ready = 1'b1;
    tick();
    chk("wr_done_valid", {63'd0, resp_valid}, 64'd0);
    chk("wr_done_ready", {63'd0, req_ready}, 64'd1);

    // Read, ACK after 3 cycles
    request(32'h3000_0004, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("rd_we", {63'd0, we_o}, 64'd0);
    tick();
    tick();
    ack = 1'b1; dat_i = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    chk("rd_rdata", {32'd0, resp_rdata}, 64'hDEAD_BEEF);
    chk("rd_err", {63'd0, resp_err}, 64'd0);
    chk("rd_stb_low", {63'd0, stb}, 64'd0);
    chk("rd_resp_valid", {63'd0, resp_valid}, 64'd1);
    tick();
    chk("rd_done_valid", {63'd0, resp_valid}, 64'd0);

    // Timeout: ACK never arrives
    resp_ready = 1'b0;
    dat_i = 32'h1234_5678;
    request(32'h3000_1000, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    stb_cycles = (stb === 1'b1) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (stb === 1'b1) stb_cycles++;
    end
    tick();
    chk("to_stb_cycles", 64'(stb_cycles), 64'd8);
    chk("to_stb_low", {63'd0, stb}, 64'd0);
    chk("to_cyc_low", {63'd0, cyc}, 64'd0);
    chk("to_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("to_err", {63'd0, resp_err}, 64'd1);
    chk("to_rdata", {32'd0, resp_rdata}, 64'd0);
    ack = 1'b1; dat_i = 32'hCAFE_F00D;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    chk("late_ack_err", {63'd0, resp_err}, 64'd1);
    chk("late_ack_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("late_ack_valid", {63'd0, resp_valid}, 64'd1);
    chk("late_ack_cyc", {63'd0, cyc}, 64'd0);
    resp_ready = 1'b1;
    tick();
    chk("to_done_valid", {63'd0, resp_valid}, 64'd0);

    // ACK in the 8th STB cycle is a success
    request(32'h3000_2000, 32'h0, 4'h3, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("edge_stb_8th", {63'd0, stb}, 64'd1);
    ack = 1'b1; dat_i = 32'h0BAD_CAFE;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    chk("edge_err", {63'd0, resp_err}, 64'd0);
    chk("edge_rdata", {32'd0, resp_rdata}, 64'h0BAD_CAFE);
    chk("edge_valid", {63'd0, resp_valid}, 64'd1);
    tick();

    // Response backpressure
    resp_ready = 1'b0;
    request(32'h3000_0008, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    ack = 1'b1; dat_i = 32'h1122_3344;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    request(32'h3000_00FC, 32'h7777_0000, 4'hC, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344 || resp_err !== 1'b0 ||
          req_ready !== 1'b0 || cyc !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", {63'd0, stable}, 64'd1);
    resp_ready = 1'b1;
    tick();
    chk("bp_release_valid", {63'd0, resp_valid}, 64'd0);
    chk("bp_release_ready", {63'd0, req_ready}, 64'd1);
    chk("bp_release_cyc", {63'd0, cyc}, 64'd0);
    tick();
    req_valid = 1'b0;
    chk("bp_accept_cyc", {63'd0, cyc}, 64'd1);
    chk("bp_accept_adr", {32'd0, adr_o}, 64'h3000_00FC);
    chk("bp_accept_sel", {60'd0, sel_o}, 64'hC);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("bp_wr_rdata", {32'd0, resp_rdata}, 64'd0);
    tick();

    // Asynchronous reset in the middle of a bus cycle
    request(32'h3000_0010, 32'h5555_AAAA, 4'hF, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_stb_before", {63'd0, stb}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc", {63'd0, cyc}, 64'd0);
    chk("mid_rst_stb", {63'd0, stb}, 64'd0);
    chk("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("post_rst_stb", {63'd0, stb}, 64'd0);
    request(32'h3000_0020, 32'h0, 4'hF, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("post_rst_adr", {32'd0, adr_o}, 64'h3000_0020);
    ack = 1'b1; dat_i = 32'hA5A5_A5A5;
    tick();
    ack = 1'b0; dat_i = 32'h0;
    chk("post_rst_rdata", {32'd0, resp_rdata}, 64'hA5A5_A5A5);
    chk("post_rst_valid", {63'd0, resp_valid}, 64'd1);
    tick();
    chk("post_rst_idle", {63'd0, req_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Wishbone classic single-transfer initiator (master) that turns a simple valid/ready request from a core-side client into one bus cycle.
- Issues exactly one transfer per request and returns the read data, or a timeout error, on a valid/ready response channel.
- Drives the slave-side Wishbone port of the user-area bridge, i.e. the control register, data SRAM and program SRAM windows.

Parameters:
- TIMEOUT, 255, max cycles STB stays high waiting for ACK before abort; legal range 1..65535.
- ADDR_W, 32, address width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  initiator can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  write data.
- req_sel  in  4  byte selects.
- req_we  in  1  1 = write, 0 = read.
- resp_valid  out  1  response present.
- resp_ready  in  1  client takes the response.
- resp_rdata  out  32  read data; 0 for writes and for errors.
- resp_err  out  1  1 = timed out, no ACK seen.
- wbm_cyc_o  out  1  Wishbone CYC.
- wbm_stb_o  out  1  Wishbone STB.
- wbm_we_o  out  1  Wishbone WE.
- wbm_sel_o  out  4  Wishbone SEL.
- wbm_adr_o  out  ADDR_W  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone ACK.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, wait counter = 0.
  - wbm_cyc_o = wbm_stb_o = wbm_we_o = 0; wbm_sel_o, wbm_adr_o, wbm_dat_o = 0.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - req_ready = 1 after reset release.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid=1: latch addr, wdata, sel and we onto the wbm_* outputs; set cyc = stb = 1; clear the counter; go to BUS.
  - wbm_ack_i is ignored.
- BUS:
  - req_ready = 0; cyc, stb and all wbm_* outputs are held stable.
  - Each edge, ACK takes priority.
  - If wbm_ack_i=1:
    - resp_rdata = we ? 0 : wbm_dat_i.
    - resp_err = 0.
    - cyc = stb = 0 on the same edge.
    - resp_valid = 1; go to RESP.
  - Else if counter == TIMEOUT-1:
    - cyc = stb = 0, resp_err = 1, resp_rdata = 0.
    - resp_valid = 1; go to RESP.
  - Else counter increments. The counter is $clog2(TIMEOUT+1) bits and never wraps.
  - Net effect: STB is high for at most TIMEOUT cycles. An ACK in the TIMEOUT-th cycle is a success.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until an edge with resp_ready=1.
  - On that edge: resp_valid = 0, go to IDLE.
  - req_ready = 0 throughout, so there is no request/response overlap.
  - wbm_ack_i is ignored; a late ACK is dropped.
- Latency:
  - Request accept at edge N → STB visible in cycle N+1.
  - With a registered-ACK slave: ACK is sampled at edge N+2, resp_valid is high from N+2.
  - Minimum turnaround is IDLE→BUS→RESP→IDLE, so 3 cycles per transfer with resp_ready tied to 1.
- Bus rules:
  - STB drops on the edge ACK is sampled, so a slave that re-checks its own ACK never double-acks.
  - CYC always equals STB; no bursts and no RMW locking.
- Write data is passed through unmodified; byte lanes are selected by sel only.

Test Plan:
- Write, ACK after 1 cycle: req addr=0x30000000, wdata=0x0000000D, sel=0xF, we=1 → wbm_adr_o=0x30000000, wbm_we_o=1; STB high 2 cycles; resp_valid with resp_err=0, resp_rdata=0.
- Read, ACK after 3 cycles: slave drives wbm_dat_i=0xDEADBEEF at ACK → resp_rdata=0xDEADBEEF, resp_err=0; STB low the cycle after ACK.
- Timeout with TIMEOUT=8 and ACK held low:
  - STB is high exactly 8 cycles, then cyc = stb = 0.
  - Response is resp_err=1, resp_rdata=0.
  - A late ACK in RESP changes nothing.
- ACK arriving in cycle 8 with TIMEOUT=8 → success; resp_err=0 and data returned.
- Backpressure: resp_ready held 0 for 5 cycles → resp_valid, resp_rdata and resp_err stay stable; req_ready=0 and a new req_valid is not accepted; the request is accepted 1 cycle after resp_ready=1.
- Reset mid-BUS: assert wb_rst_i while STB=1 → cyc, stb and resp_valid go to 0 without waiting for a clock edge; after release req_ready=1 and the next transfer completes normally.
